// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor that computes D = A - B - Bin. It handles one bit per
//   clock, LSB first, and needs size RUN cycles per operation. The controlling
//   FSM uses a start/done handshake.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     start  request, sampled only while idle
//     A, B   minuend / subtrahend, latched when start is accepted
//     Bin    borrow-in, latched when start is accepted
//     busy   high while running and during the done cycle
//     done   one-cycle pulse, D/Bout valid
//     D      difference modulo 2^size, held until the next completion
//     Bout   final borrow-out (unsigned underflow), held like D
//     ovf    (only with SERIAL_SUB_SIGNED_EN) signed two's-complement overflow
//
//   Optional feature: define SERIAL_SUB_SIGNED_EN to add the ovf output.
module serial_subtractor #(
   parameter int size = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [size-1:0] A,
   input  logic [size-1:0] B,
   input  logic            Bin,
   output logic            busy,
   output logic            done,
   output logic [size-1:0] D,
`ifdef SERIAL_SUB_SIGNED_EN
   output logic            ovf,
`endif
   output logic            Bout
);

   localparam int CW = (size > 1) ? $clog2(size) : 1;
   localparam logic [CW-1:0] LAST = CW'(size - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            br;
   logic [size-1:0] a_sh, b_sh, res_sh;

   // One full-subtractor slice on the current LSBs.
   logic            a, b, d_bit, nb;
   logic [size-1:0] res_nxt;

   always_comb begin
      a     = a_sh[0];
      b     = b_sh[0];
      d_bit = a ^ b ^ br;
      nb    = (~a & b) | (~a & br) | (b & br);
      // The difference bit enters at the MSB. After size shifts, bit 0 has
      // reached position 0.
      res_nxt           = res_sh >> 1;
      res_nxt[size-1]   = d_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         br     <= 1'b0;
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         D      <= '0;
         Bout   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
         ovf    <= 1'b0;
`endif
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sh  <= A;
                  b_sh  <= B;
                  br    <= Bin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= res_nxt;
               br     <= nb;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  // The outputs load only here, so D and Bout stay stable
                  // between done pulses.
                  D     <= res_nxt;
                  Bout  <= nb;
`ifdef SERIAL_SUB_SIGNED_EN
                  // br is the borrow into the MSB and nb is the borrow out of it.
                  ovf   <= br ^ nb;
`endif
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] A = '0, B = '0, D;
   logic       Bin = 1'b0, busy, done, Bout;
`ifdef SERIAL_SUB_SIGNED_EN
   logic       ovf;
`endif

   int total = 0;
   int bad   = 0;

   serial_subtractor #(.size(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
      .busy(busy), .done(done), .D(D),
`ifdef SERIAL_SUB_SIGNED_EN
      .ovf(ovf),
`endif
      .Bout(Bout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Runs one operation. Inputs change on the falling edge and outputs are
   // sampled on the falling edge. idx counts falling edges after the accept
   // edge E0, so done is expected at idx 8 and busy is high for idx 0..8.
   // With poke set, start is re-asserted and the operands are scrambled at
   // RUN cycles 3 and 6.
   task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [7:0] ed, input logic eb,
                        input logic eo, input bit poke);
      int done_at = -1;
      int busy_n  = 0;
      int dones   = 0;
      @(negedge clk);
      A = a; B = b; Bin = bin; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int idx = 0; idx < 40; idx++) begin
         if (idx > 0) @(negedge clk);
         if (poke && (idx == 3 || idx == 6)) begin
            start = 1'b1; A = 8'h11; B = 8'h99; Bin = 1'b1;
         end else start = 1'b0;
         if (busy) busy_n++;
         if (done) begin
            dones++;
            if (done_at < 0) begin
               done_at = idx;
               chk({tag, ".D"}, 32'(D), 32'(ed));
               chk({tag, ".Bout"}, 32'(Bout), 32'(eb));
`ifdef SERIAL_SUB_SIGNED_EN
               chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
`endif
            end
         end
         if (done_at >= 0 && idx >= done_at + 3) break;
      end
      start = 1'b0;
      chk({tag, ".lat"}, 32'(done_at), 32'd8);
      chk({tag, ".busy_n"}, 32'(busy_n), 32'd9);
      chk({tag, ".ndone"}, 32'(dones), 32'd1);
      chk({tag, ".hold"}, 32'(D), 32'(ed));
      if (eo === 1'bx) chk({tag, ".eo"}, 32'd0, 32'd1);
   endtask

   initial begin
      int hit;
      // Reset state
      #12;
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.D", 32'(D), 32'd0);
      chk("rst.Bout", 32'(Bout), 32'd0);
`ifdef SERIAL_SUB_SIGNED_EN
      chk("rst.ovf", 32'(ovf), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      do_op("t100_37", 8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 1'b0, 1'b0);
      do_op("t5_10_1", 8'd5, 8'd10, 1'b1, 8'hFA, 1'b1, 1'b0, 1'b0);
      do_op("t80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
      do_op("t200_55", 8'd200, 8'd55, 1'b0, 8'd145, 1'b0, 1'b0, 1'b1);
      do_op("t00_ff_1", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
      do_op("t7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);

      // Reset asserted mid-RUN: the operation is discarded and no done follows.
      @(negedge clk);
      A = 8'd9; B = 8'd3; Bin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst.busy", 32'(busy), 32'd0);
      chk("mrst.done", 32'(done), 32'd0);
      chk("mrst.D", 32'(D), 32'd0);
      chk("mrst.Bout", 32'(Bout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      hit = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) hit++;
      end
      chk("mrst.quiet", 32'(hit), 32'd0);
      do_op("tff_ff", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Back-to-back with start held high. The first op is 0-0-1. The second
      // op is accepted in the idle cycle after done.
      @(negedge clk);
      A = 8'h00; B = 8'h00; Bin = 1'b1; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      hit = -1;
      for (int idx = 0; idx < 30; idx++) begin
         if (idx > 0) @(negedge clk);
         if (idx == 1) begin A = 8'd3; B = 8'd1; Bin = 1'b0; end
         if (idx == 8) begin
            chk("b2b.done1", 32'(done), 32'd1);
            chk("b2b.D1", 32'(D), 32'hFF);
            chk("b2b.Bout1", 32'(Bout), 32'd1);
         end
         if (idx == 9)  chk("b2b.idle", 32'(busy), 32'd0);
         if (idx == 10) chk("b2b.acc", 32'(busy), 32'd1);
         if (idx == 12) chk("b2b.held", 32'(D), 32'hFF);
         if (idx > 9 && done) begin hit = idx; break; end
      end
      start = 1'b0;
      chk("b2b.lat2", 32'(hit), 32'd18);
      chk("b2b.D2", 32'(D), 32'd2);
      chk("b2b.Bout2", 32'(Bout), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
